// File: rtl/wb_pipe_if.sv
// Bus bundle for wb_pipe: MEM-side write lanes, stage controls, WB outputs
// and the forwarding query ports.
interface wb_pipe_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NQ     = 4
);
  localparam int unsigned PEND_W = $clog2(LANES*DEPTH+1);

  logic [LANES-1:0]        mem_we;
  logic [LANES*ADDR_W-1:0] mem_waddr;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic                    stall_mem;
  logic                    stall_wb;
  logic                    flush;
  logic [LANES-1:0]        wb_we;
  logic [LANES*ADDR_W-1:0] wb_waddr;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [NQ*ADDR_W-1:0]    q_addr;
  logic [NQ-1:0]           q_hit;
  logic [NQ*DATA_W-1:0]    q_data;
  logic [PEND_W-1:0]       pending;

  modport master (
    output mem_we, mem_waddr, mem_wdata, stall_mem, stall_wb, flush, q_addr,
    input  wb_we, wb_waddr, wb_wdata, q_hit, q_data, pending
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, stall_mem, stall_wb, flush, q_addr,
    output wb_we, wb_waddr, wb_wdata, q_hit, q_data, pending
  );
endinterface

// File: rtl/wb_pipe.sv
// MEM->WB write-back pipeline of DEPTH stages x LANES lanes with stall/flush
// control, a valid-write counter and register-only operand forwarding.
module wb_pipe #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NQ     = 4
) (
  input logic     clk,
  input logic     rst_n,
  wb_pipe_if.slave bus
);
  localparam int unsigned PEND_W = $clog2(LANES*DEPTH+1);
  localparam int unsigned AW_L   = LANES*ADDR_W;
  localparam int unsigned DW_L   = LANES*DATA_W;

  logic [LANES-1:0]  r_we   [DEPTH];
  logic [AW_L-1:0]   r_addr [DEPTH];
  logic [DW_L-1:0]   r_data [DEPTH];
  logic [PEND_W-1:0] r_pending;

  logic [LANES-1:0]  w_we_nxt   [DEPTH];
  logic [AW_L-1:0]   w_addr_nxt [DEPTH];
  logic [DW_L-1:0]   w_data_nxt [DEPTH];
  logic [PEND_W-1:0] w_pending_nxt;

  logic [LANES-1:0]  w_cap_we;
  logic [AW_L-1:0]   w_cap_addr;
  logic [DW_L-1:0]   w_cap_data;

  logic [NQ-1:0]        w_q_hit;
  logic [NQ*DATA_W-1:0] w_q_data;

  // Writes to register 0 are dropped at the door so they never occupy a slot.
  always_comb begin
    w_cap_we   = '0;
    w_cap_addr = '0;
    w_cap_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (bus.mem_we[i] && (bus.mem_waddr[i*ADDR_W +: ADDR_W] != '0)) begin
        w_cap_we[i]                   = 1'b1;
        w_cap_addr[i*ADDR_W +: ADDR_W] = bus.mem_waddr[i*ADDR_W +: ADDR_W];
        w_cap_data[i*DATA_W +: DATA_W] = bus.mem_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for every stage; hold is the default.
  always_comb begin
    for (int s = 0; s < int'(DEPTH); s++) begin
      w_we_nxt[s]   = r_we[s];
      w_addr_nxt[s] = r_addr[s];
      w_data_nxt[s] = r_data[s];
    end
    if (bus.flush) begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        w_we_nxt[s]   = '0;
        w_addr_nxt[s] = '0;
        w_data_nxt[s] = '0;
      end
    end else begin
      if (!bus.stall_mem) begin
        w_we_nxt[0]   = w_cap_we;
        w_addr_nxt[0] = w_cap_addr;
        w_data_nxt[0] = w_cap_data;
      end else if (!bus.stall_wb) begin
        w_we_nxt[0]   = '0;
        w_addr_nxt[0] = '0;
        w_data_nxt[0] = '0;
      end
      for (int s = 1; s < int'(DEPTH); s++) begin
        if (!bus.stall_wb) begin
          w_we_nxt[s]   = r_we[s-1];
          w_addr_nxt[s] = r_addr[s-1];
          w_data_nxt[s] = r_data[s-1];
        end
      end
    end
    w_pending_nxt = '0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      for (int i = 0; i < int'(LANES); i++) begin
        w_pending_nxt = w_pending_nxt + PEND_W'(w_we_nxt[s][i]);
      end
    end
  end

  // Stage registers and write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        r_we[s]   <= '0;
        r_addr[s] <= '0;
        r_data[s] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        r_we[s]   <= w_we_nxt[s];
        r_addr[s] <= w_addr_nxt[s];
        r_data[s] <= w_data_nxt[s];
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Scan oldest-to-youngest, low-to-high lane so the last match is the winner.
  always_comb begin
    w_q_hit  = '0;
    w_q_data = '0;
    for (int k = 0; k < int'(NQ); k++) begin
      if (bus.q_addr[k*ADDR_W +: ADDR_W] != '0) begin
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
          for (int i = 0; i < int'(LANES); i++) begin
            if (r_we[s][i] &&
                (r_addr[s][i*ADDR_W +: ADDR_W] == bus.q_addr[k*ADDR_W +: ADDR_W])) begin
              w_q_hit[k]                  = 1'b1;
              w_q_data[k*DATA_W +: DATA_W] = r_data[s][i*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  assign bus.wb_we    = r_we[DEPTH-1];
  assign bus.wb_waddr = r_addr[DEPTH-1];
  assign bus.wb_wdata = r_data[DEPTH-1];
  assign bus.pending  = r_pending;
  assign bus.q_hit    = w_q_hit;
  assign bus.q_data   = w_q_data;

  // MEM advancing into a frozen WB would overwrite an unretired entry.
  a_illegal_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(!bus.stall_mem && bus.stall_wb));

endmodule
